// File: rtl/write_buffer_gen_pkg.sv
// Shared constants and byte-merge helpers for the posted-write buffer.
package write_buffer_gen_pkg;

    localparam int unsigned DEF_ADDR_W = 30;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 4;

    // Widest data path the shared byte-merge helper covers; callers zero-extend into it.
    localparam int unsigned MAX_DATA_W = 512;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Per-byte mux: enabled bytes come from new_word, the rest keep old_word.
    function automatic logic [MAX_DATA_W-1:0] bytemerge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        for (int i = 0; i < int'(MAX_BE_W); i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/write_buffer_gen_fwd_merge.sv
// Forwarding lookup: merges all matching queued entries, oldest to youngest.
module wb_fwd_merge
    import write_buffer_gen_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    localparam int unsigned BE_W  = DATA_W / 8,
    localparam int unsigned PTR_W = clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             vld,
    input  logic [DEPTH-1:0][ADDR_W-1:0] adr,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    input  logic [DEPTH-1:0][BE_W-1:0]   be,
    input  logic [PTR_W-1:0]             head,
    input  logic [ADDR_W-1:0]            fwdadr,
    output logic [DATA_W-1:0]            fwddata,
    output logic [BE_W-1:0]              fwdbyteen
);

    logic [PTR_W-1:0] idx;

    // Walking from head makes younger matches overwrite older bytes.
    always_comb begin
        fwddata   = '0;
        fwdbyteen = '0;
        idx       = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head + PTR_W'(k);
            if (vld[idx] && (adr[idx] == fwdadr)) begin
                fwddata   = DATA_W'(bytemerge(MAX_DATA_W'(fwddata), MAX_DATA_W'(data[idx]),
                                              MAX_BE_W'(be[idx])));
                fwdbyteen = fwdbyteen | be[idx];
            end
        end
    end

endmodule

// File: rtl/write_buffer_gen.sv
// Posted-write buffer: coalesces same-word writes, forwards queued bytes, drains in order.
module write_buffer_gen
    import write_buffer_gen_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    localparam int unsigned BE_W  = DATA_W / 8,
    localparam int unsigned PTR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] data,
    input  logic [BE_W-1:0]   byteen,
    input  logic              en,
    output logic              done,
    input  logic [ADDR_W-1:0] fwdadr,
    output logic              fwdhit,
    output logic [DATA_W-1:0] fwddata,
    output logic [BE_W-1:0]   fwdbyteen,
    input  logic              flush,
    output logic              flushdone,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] memadr,
    output logic [DATA_W-1:0] memdata,
    output logic [BE_W-1:0]   membyteen,
    output logic              memen,
    input  logic              memdone
);

    logic [DEPTH-1:0][ADDR_W-1:0] ent_adr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0][BE_W-1:0]   ent_be;
    logic [DEPTH-1:0]             ent_vld;
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [PTR_W-1:0]             tail_m1;
    logic [PTR_W:0]               count_next;
    logic                         flushpend;
    logic                         merge;
    logic                         push;
    logic                         pop;

    // Merge only into the newest entry, and never into the head being presented to memory.
    assign tail_m1 = tail - PTR_W'(1);
    assign merge   = en && (count >= (PTR_W+1)'(2)) && (ent_adr[tail_m1] == adr);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign done    = merge | ~full;
    assign push    = en & ~merge & ~full;

    assign memen     = ent_vld[head];
    assign memadr    = ent_adr[head];
    assign memdata   = ent_data[head];
    assign membyteen = ent_be[head];
    assign pop       = memdone & memen;

    assign flushdone = ~flushpend & empty;
    assign fwdhit    = |fwdbyteen;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (PTR_W+1)'(1);
        end else if (!push && pop) begin
            count_next = count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_vld   <= '0;
            flushpend <= 1'b0;
        end else begin
            if (push) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            count <= count_next;
            if (count_next == '0) begin
                flushpend <= 1'b0;
            end else if (flush) begin
                flushpend <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_adr[tail]  <= adr;
            ent_data[tail] <= data;
            ent_be[tail]   <= byteen;
        end else if (merge) begin
            ent_data[tail_m1] <= DATA_W'(bytemerge(MAX_DATA_W'(ent_data[tail_m1]),
                                                   MAX_DATA_W'(data), MAX_BE_W'(byteen)));
            ent_be[tail_m1]   <= ent_be[tail_m1] | byteen;
        end
    end

    wb_fwd_merge #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .vld       (ent_vld),
        .adr       (ent_adr),
        .data      (ent_data),
        .be        (ent_be),
        .head      (head),
        .fwdadr    (fwdadr),
        .fwddata   (fwddata),
        .fwdbyteen (fwdbyteen)
    );

endmodule
